// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the register writeback stage.
// The optional forwarding ports in reg_writeback are enabled by defining WB_FWD_EN.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // One buffered load result; the FIFO stores it flattened as {regAddr, data}.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wbEntry_t;

    // Source that owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2,
        SEL_LOAD = 2'd3
    } wbSel_e;

    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering load results that lose arbitration.
// Head data is read combinationally so a pop can be written in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W + DATA_W,
    parameter int DEPTH = 2,
    localparam int CNT_W = countWidth(DEPTH),
    localparam int PTR_W = ptrWidth(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [WIDTH-1:0] slotReg [DEPTH];
    logic             pushEff;
    logic             popEff;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (countReg == CNT_W'(DEPTH));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign pushEff  = push && !full;
    assign popEff   = pop && !empty;
    assign headData = slotReg[rdPtrReg];

    always_ff @(posedge CLK) begin
        if (RST) begin
            countReg <= '0;
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (pushEff) begin
                wrPtrReg <= wrapInc(wrPtrReg);
            end
            if (popEff) begin
                rdPtrReg <= wrapInc(rdPtrReg);
            end
            case ({pushEff, popEff})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Payload slots carry no reset; validity is tracked by the count alone.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
        always_ff @(posedge CLK) begin
            if (pushEff && (wrPtrReg == PTR_W'(gi))) begin
                slotReg[gi] <= pushData;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: merges ALU results and load returns into one register-file
// write per cycle (ALU > buffered load > direct load). Define WB_FWD_EN for forwarding ports.
module reg_writeback #(
    parameter int DATA_W     = wb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          AluValid,
    input  logic [wb_pkg::REG_ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0]             AluData,
    input  logic                          LdValid,
    input  logic [wb_pkg::REG_ADDR_W-1:0] LdReg,
    input  logic [DATA_W-1:0]             LdData,
    output logic                          LdReady,
    output logic                          RegWrite,
    output logic [wb_pkg::REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]             WriteData,
    output logic                          Busy
`ifdef WB_FWD_EN
    ,
    input  logic [wb_pkg::REG_ADDR_W-1:0] ReadReg1,
    input  logic [wb_pkg::REG_ADDR_W-1:0] ReadReg2,
    output logic                          Fwd1,
    output logic                          Fwd2,
    output logic [DATA_W-1:0]             FwdData1,
    output logic [DATA_W-1:0]             FwdData2
`endif
);

    import wb_pkg::*;

    localparam int ENTRY_W = REG_ADDR_W + DATA_W;
    localparam int CNT_W   = countWidth(FIFO_DEPTH);

    logic                  fifoPush;
    logic                  fifoPop;
    logic [ENTRY_W-1:0]    fifoHead;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [CNT_W-1:0]      fifoCount;
    logic                  ldAccept;
    wbSel_e                sel;
    logic [REG_ADDR_W-1:0] nextReg;
    logic [DATA_W-1:0]     nextData;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (fifoPush),
        .pushData ({LdReg, LdData}),
        .pop      (fifoPop),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Ready depends on occupancy only, so a full FIFO refuses even while popping.
    assign LdReady  = (fifoCount < CNT_W'(FIFO_DEPTH));
    assign ldAccept = LdValid && LdReady;
    assign Busy     = !fifoEmpty || RegWrite;

    always_comb begin
        sel = SEL_NONE;
        if (AluValid) begin
            sel = SEL_ALU;
        end else if (!fifoEmpty) begin
            sel = SEL_FIFO;
        end else if (ldAccept) begin
            sel = SEL_LOAD;
        end
    end

    // Any accepted load that is not written directly goes behind older loads.
    assign fifoPop  = (sel == SEL_FIFO);
    assign fifoPush = ldAccept && (sel != SEL_LOAD);

    always_comb begin
        nextReg  = WriteReg;
        nextData = WriteData;
        case (sel)
            SEL_ALU: begin
                nextReg  = AluReg;
                nextData = AluData;
            end
            SEL_FIFO: begin
                nextReg  = fifoHead[ENTRY_W-1:DATA_W];
                nextData = fifoHead[DATA_W-1:0];
            end
            SEL_LOAD: begin
                nextReg  = LdReg;
                nextData = LdData;
            end
            default: begin
                nextReg  = WriteReg;
                nextData = WriteData;
            end
        endcase
    end

    // Writes to r0 still consume their entry and update address/data, but never enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite  <= (sel != SEL_NONE) && (nextReg != '0);
            WriteReg  <= nextReg;
            WriteData <= nextData;
        end
    end

`ifdef WB_FWD_EN
    logic [REG_ADDR_W-1:0] readReg [2];
    logic [1:0]            fwdHit;

    assign readReg[0] = ReadReg1;
    assign readReg[1] = ReadReg2;

    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
        assign fwdHit[gi] = RegWrite && (readReg[gi] == WriteReg) && (WriteReg != '0);
    end

    assign Fwd1     = fwdHit[0];
    assign Fwd2     = fwdHit[1];
    assign FwdData1 = WriteData;
    assign FwdData2 = WriteData;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus a randomized run
// against a queue-based model of the writeback priority rules.
module tb_reg_writeback;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          AluValid;
    logic [4:0]    AluReg;
    logic [DW-1:0] AluData;
    logic          LdValid;
    logic [4:0]    LdReg;
    logic [DW-1:0] LdData;
    logic          LdReady;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [DW-1:0] WriteData;
    logic          Busy;
`ifdef WB_FWD_EN
    logic [4:0]    ReadReg1;
    logic [4:0]    ReadReg2;
    logic          Fwd1;
    logic          Fwd2;
    logic [DW-1:0] FwdData1;
    logic [DW-1:0] FwdData2;
`endif

    reg_writeback #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AluValid  (AluValid),
        .AluReg    (AluReg),
        .AluData   (AluData),
        .LdValid   (LdValid),
        .LdReg     (LdReg),
        .LdData    (LdData),
        .LdReady   (LdReady),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Busy      (Busy)
`ifdef WB_FWD_EN
        ,
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .Fwd1      (Fwd1),
        .Fwd2      (Fwd2),
        .FwdData1  (FwdData1),
        .FwdData2  (FwdData2)
`endif
    );

    always #5 CLK = ~CLK;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: pending loads in arrival order plus the expected write port.
    logic [4+DW:0] modelQ [$];
    logic          expWe   = 1'b0;
    logic [4:0]    expReg  = '0;
    logic [DW-1:0] expData = '0;

    function automatic bit modelReady();
        return modelQ.size() < DEPTH;
    endfunction

    // Advance one clock: update the model from the current inputs, then step the DUT.
    task automatic tick();
        bit            acc;
        logic [4+DW:0] e;
        acc = LdValid && modelReady();
        if (RST) begin
            modelQ.delete();
            expWe = 1'b0; expReg = '0; expData = '0;
        end else if (AluValid) begin
            expWe = (AluReg != 0); expReg = AluReg; expData = AluData;
            if (acc) modelQ.push_back({LdReg, LdData});
        end else if (modelQ.size() > 0) begin
            e = modelQ.pop_front();
            expReg = e[4+DW:DW]; expData = e[DW-1:0]; expWe = (expReg != 0);
            if (acc) modelQ.push_back({LdReg, LdData});
        end else if (acc) begin
            expWe = (LdReg != 0); expReg = LdReg; expData = LdData;
        end else begin
            expWe = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        AluValid = 0; AluReg = '0; AluData = '0;
        LdValid = 0; LdReg = '0; LdData = '0;
    endtask

    task automatic test_reset();
        RST = 1; idleInputs();
        tick(); tick();
        RST = 0;
        tick();
        checkCount++;
        if (RegWrite !== 1'b0 || LdReady !== 1'b1 || Busy !== 1'b0)
            $display("FAIL reset_idle: RegWrite=%b LdReady=%b Busy=%b required 0/1/0", RegWrite, LdReady, Busy);
        else passCount++;
        checkCount++;
        if (WriteReg !== 5'd0 || WriteData !== '0)
            $display("FAIL reset_regs: WriteReg=%0d WriteData=%h required 0/0", WriteReg, WriteData);
        else passCount++;
        $display("test_reset done: RegWrite=%b LdReady=%b Busy=%b", RegWrite, LdReady, Busy);
    endtask

    task automatic test_alu();
        AluValid = 1; AluReg = 5'd5; AluData = 32'h1234;
        tick();
        idleInputs();
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'h1234)
            $display("FAIL alu_write: got we=%b r%0d=%h required 1 r5=1234", RegWrite, WriteReg, WriteData);
        else passCount++;
        tick();
        checkCount++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd5 || WriteData !== 32'h1234)
            $display("FAIL idle_hold: got we=%b r%0d=%h required 0 r5=1234", RegWrite, WriteReg, WriteData);
        else passCount++;
        $display("test_alu done: r%0d=%h", WriteReg, WriteData);
    endtask

    task automatic test_bypass();
        LdValid = 1; LdReg = 5'd9; LdData = 32'h0BAD;
        checkCount++;
        if (LdReady !== 1'b1) $display("FAIL bypass_ready: LdReady=%b required 1", LdReady);
        else passCount++;
        tick();
        idleInputs();
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'h0BAD || Busy !== 1'b1)
            $display("FAIL bypass_write: got we=%b r%0d=%h busy=%b required 1 r9=0bad busy=1",
                     RegWrite, WriteReg, WriteData, Busy);
        else passCount++;
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_backpressure();
        AluValid = 1; AluReg = 5'd10; AluData = 32'h10;
        LdValid = 1; LdReg = 5'd7; LdData = 32'hAA;
        tick();
        AluReg = 5'd11; AluData = 32'h11;
        LdReg = 5'd8; LdData = 32'hBB;
        tick();
        AluReg = 5'd12; AluData = 32'h12;
        LdReg = 5'd9; LdData = 32'hCC;
        checkCount++;
        if (LdReady !== 1'b0) $display("FAIL full_ready: LdReady=%b required 0", LdReady);
        else passCount++;
        tick();
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd12 || WriteData !== 32'h12)
            $display("FAIL alu_priority: got r%0d=%h required r12=12", WriteReg, WriteData);
        else passCount++;
        AluValid = 0;
        checkCount++;
        if (LdReady !== 1'b0) $display("FAIL full_pop_ready: LdReady=%b required 0", LdReady);
        else passCount++;
        tick();
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || WriteData !== 32'hAA)
            $display("FAIL drain_first: got we=%b r%0d=%h required 1 r7=aa", RegWrite, WriteReg, WriteData);
        else passCount++;
        checkCount++;
        if (LdReady !== 1'b1) $display("FAIL drain_ready: LdReady=%b required 1", LdReady);
        else passCount++;
        tick();
        LdValid = 0;
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || WriteData !== 32'hBB)
            $display("FAIL drain_second: got we=%b r%0d=%h required 1 r8=bb", RegWrite, WriteReg, WriteData);
        else passCount++;
        tick();
        checkCount++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'hCC)
            $display("FAIL drain_third: got we=%b r%0d=%h required 1 r9=cc", RegWrite, WriteReg, WriteData);
        else passCount++;
        tick();
        checkCount++;
        if (RegWrite !== 1'b0 || Busy !== 1'b0 || WriteReg !== 5'd9)
            $display("FAIL drain_done: got we=%b busy=%b r%0d required 0/0/r9", RegWrite, Busy, WriteReg);
        else passCount++;
        $display("test_backpressure done");
    endtask

    task automatic test_zero_reg();
        AluValid = 1; AluReg = 5'd0; AluData = 32'hFFFF;
        tick();
        idleInputs();
        checkCount++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'hFFFF)
            $display("FAIL zero_reg: got we=%b r%0d=%h required 0 r0=ffff", RegWrite, WriteReg, WriteData);
        else passCount++;
        tick();
        $display("test_zero_reg done");
    endtask

    task automatic test_reset_flush();
        AluValid = 1; AluReg = 5'd3; AluData = 32'h3;
        LdValid = 1; LdReg = 5'd20; LdData = 32'h20;
        tick();
        LdReg = 5'd21; LdData = 32'h21;
        tick();
        RST = 1;
        tick();
        RST = 0; idleInputs();
        checkCount++;
        if (RegWrite !== 1'b0 || LdReady !== 1'b1 || Busy !== 1'b0)
            $display("FAIL flush_state: we=%b LdReady=%b busy=%b required 0/1/0", RegWrite, LdReady, Busy);
        else passCount++;
        tick(); tick();
        checkCount++;
        if (RegWrite !== 1'b0 || Busy !== 1'b0)
            $display("FAIL flush_nowrite: we=%b busy=%b r%0d required 0/0", RegWrite, Busy, WriteReg);
        else passCount++;
        $display("test_reset_flush done");
    endtask

`ifdef WB_FWD_EN
    task automatic test_forward();
        AluValid = 1; AluReg = 5'd3; AluData = 32'h55;
        tick();
        idleInputs();
        ReadReg1 = 5'd3; ReadReg2 = 5'd4;
        #1;
        checkCount++;
        if (Fwd1 !== 1'b1 || FwdData1 !== 32'h55 || Fwd2 !== 1'b0)
            $display("FAIL fwd_hit: Fwd1=%b data=%h Fwd2=%b required 1/55/0", Fwd1, FwdData1, Fwd2);
        else passCount++;
        AluValid = 1; AluReg = 5'd0; AluData = 32'h77;
        tick();
        idleInputs();
        ReadReg2 = 5'd0;
        #1;
        checkCount++;
        if (Fwd2 !== 1'b0) $display("FAIL fwd_r0: Fwd2=%b required 0", Fwd2);
        else passCount++;
        tick();
        $display("test_forward done");
    endtask
`endif

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            RST      = ($urandom_range(0, 99) < 2);
            AluValid = ($urandom_range(0, 99) < 40);
            AluReg   = 5'($urandom_range(0, 31));
            AluData  = $urandom;
            LdValid  = ($urandom_range(0, 99) < 65);
            LdReg    = 5'($urandom_range(0, 31));
            LdData   = $urandom;
`ifdef WB_FWD_EN
            ReadReg1 = 5'($urandom_range(0, 31));
            ReadReg2 = WriteReg;
`endif
            #1;
            checkCount++;
            if (LdReady !== modelReady()) begin
                errs++;
                $display("FAIL rand_ready[%0d]: LdReady=%b required %b", i, LdReady, modelReady());
            end else passCount++;
            tick();
            checkCount++;
            if (RegWrite !== expWe || WriteReg !== expReg || WriteData !== expData ||
                Busy !== (expWe || modelQ.size() > 0)) begin
                errs++;
                $display("FAIL rand_write[%0d]: got we=%b r%0d=%h busy=%b required we=%b r%0d=%h busy=%b",
                         i, RegWrite, WriteReg, WriteData, Busy, expWe, expReg, expData,
                         expWe || modelQ.size() > 0);
            end else passCount++;
        end
        RST = 0; idleInputs();
        $display("test_random done: %0d errors", errs);
    endtask

    initial begin
        RST = 1;
        idleInputs();
`ifdef WB_FWD_EN
        ReadReg1 = '0; ReadReg2 = '0;
`endif
        test_reset();
        test_alu();
        test_bypass();
        test_backpressure();
        test_zero_reg();
        test_reset_flush();
`ifdef WB_FWD_EN
        test_forward();
`endif
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
